phi0_tracker: RTL and testbench

PHI0_TRACKER -- requirements
Module: phi0_tracker

---
 rtl/phi0_tracker_if.sv | 19 +
 rtl/phi0_tracker.sv | 96 +++++++++
 tb/tb_phi0_tracker.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phi0_tracker_if.sv
// phi0_tracker_if: phi0 edge pulses in, phase/period measurements and lock status out.
interface phi0_tracker_if #(parameter int CNT_W = 8);
    logic             phi0_posedge;
    logic             phi0_negedge;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             sample_stb;
    logic             locked;
    logic             timeout;
    modport master (
        output phi0_posedge, phi0_negedge,
        input  phase_cnt, period, high_time, sample_stb, locked, timeout
    );
    modport slave (
        input  phi0_posedge, phi0_negedge,
        output phase_cnt, period, high_time, sample_stb, locked, timeout
    );
endinterface

// File: rtl/phi0_tracker.sv
// phi0_tracker: measures phi0 period/high time, locks on a stable period,
// strobes at a fixed offset in each locked cycle and flags a stopped phi0.
module phi0_tracker #(
    parameter int CNT_W      = 8,
    parameter int SAMPLE_OFS = 10,
    parameter int LOCK_N     = 4,
    parameter int TOL        = 2
) (
    input logic           clk,
    input logic           rst,
    phi0_tracker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [MW-1:0]    match_q, match_d;
    logic             sample_stb_q, sample_stb_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] m, diff;
    logic             sat, in_tol;

    always_comb begin
        sat          = phase_cnt_q == MAX;
        m            = phase_cnt_q + CNT_W'(1);
        // subtract the smaller from the larger so the deviation never wraps
        diff         = (m >= period_q) ? m - period_q : period_q - m;
        in_tol       = diff <= CNT_W'(TOL);
        state_d      = state_q;
        match_d      = match_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        timeout_d    = timeout_q;
        phase_cnt_d  = bus.phi0_posedge ? '0 : (sat ? MAX : phase_cnt_q + CNT_W'(1));
        if (bus.phi0_posedge) begin
            timeout_d = 1'b0;
            if (state_q == IDLE || sat) begin
                state_d = ACQ;
                match_d = '0;
            end else begin
                period_d = m;
                if (state_q == LOCK) begin
                    if (!in_tol) begin
                        state_d = ACQ;
                        match_d = MW'(1);
                    end
                end else begin
                    match_d = (match_q == '0 || in_tol) ? match_q + MW'(1) : MW'(1);
                    if (match_d == MW'(LOCK_N)) state_d = LOCK;
                end
            end
        end else begin
            if (bus.phi0_negedge && state_q != IDLE) high_time_d = m;
            if (phase_cnt_d == MAX) begin
                state_d   = IDLE;
                timeout_d = 1'b1;
            end
        end
        sample_stb_d = state_d == LOCK && phase_cnt_d == CNT_W'(SAMPLE_OFS);
        locked_d     = state_d == LOCK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_cnt_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            match_q      <= '0;
            sample_stb_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            match_q      <= match_d;
            sample_stb_q <= sample_stb_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.phase_cnt  = phase_cnt_q;
    assign bus.period     = period_q;
    assign bus.high_time  = high_time_q;
    assign bus.sample_stb = sample_stb_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_phi0_tracker.sv
// tb_phi0_tracker: scenario tasks drive phi0 cycles; expected status after each
// rise is queued when the rise is driven and compared once the DUT has taken it.
module tb_phi0_tracker;
    typedef struct packed {
        logic [7:0] period;
        logic [7:0] high_time;
        logic       locked;
        logic       timeout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t got, e;

    phi0_tracker_if #(.CNT_W(8)) bus();
    phi0_tracker u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t obs();
        return '{period: bus.period, high_time: bus.high_time, locked: bus.locked, timeout: bus.timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rise(input logic with_neg);
        bus.phi0_posedge = 1'b1;
        bus.phi0_negedge = with_neg;
        tick();
        bus.phi0_posedge = 1'b0;
        bus.phi0_negedge = 1'b0;
    endtask

    task automatic rest(input int len, input int hi);
        repeat (hi - 1) tick();
        bus.phi0_negedge = 1'b1;
        tick();
        bus.phi0_negedge = 1'b0;
        repeat (len - hi - 1) tick();
    endtask

    task automatic test_reset();
        bus.phi0_posedge = 1'b0;
        bus.phi0_negedge = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if (obs() !== exp_t'(0) || bus.phase_cnt !== 8'd0 || bus.sample_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got %h pc=%0d stb=%b, expected 0", obs(), bus.phase_cnt, bus.sample_stb);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{period: (k == 1) ? 8'd0 : 8'd28, high_time: (k == 1) ? 8'd0 : 8'd14,
                           locked: k == 5, timeout: 1'b0});
            drive_rise(1'b0);
            got = obs();
            e = sb.pop_front();
            vectors++;
            if (got !== e || bus.phase_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL lock rise%0d: got %h pc=%0d, expected %h pc=0", k, got, bus.phase_cnt, e);
            end
            rest(28, 14);
        end
        vectors++;
        if (obs() !== exp_t'{8'd28, 8'd14, 1'b1, 1'b0} || bus.phase_cnt !== 8'd27) begin
            miscompares++;
            $display("FAIL lock end: got %h pc=%0d", obs(), bus.phase_cnt);
        end
    endtask

    task automatic test_sample_stb();
        for (int c = 0; c < 3; c++) begin
            int n = 0;
            sb.push_back('{period: 8'd28, high_time: 8'd14, locked: 1'b1, timeout: 1'b0});
            drive_rise(1'b0);
            got = obs();
            e = sb.pop_front();
            vectors++;
            if (got !== e || bus.sample_stb !== 1'b0) begin
                miscompares++;
                $display("FAIL stb rise%0d: got %h stb=%b, expected %h stb=0", c, got, bus.sample_stb, e);
            end
            for (int i = 1; i < 28; i++) begin
                bus.phi0_negedge = (i == 14);
                tick();
                bus.phi0_negedge = 1'b0;
                if (bus.sample_stb) begin
                    n++;
                    vectors++;
                    if (bus.phase_cnt !== 8'd10) begin
                        miscompares++;
                        $display("FAIL stb phase: got pc=%0d, expected 10", bus.phase_cnt);
                    end
                end
            end
            vectors++;
            if (n != 1) begin
                miscompares++;
                $display("FAIL stb count cycle%0d: got %0d, expected 1", c, n);
            end
        end
    endtask

    task automatic test_tolerance();
        exp_t t[6];
        int   len[6];
        t[0] = '{8'd28, 8'd14, 1'b1, 1'b0}; len[0] = 30;
        t[1] = '{8'd30, 8'd14, 1'b1, 1'b0}; len[1] = 34;
        t[2] = '{8'd34, 8'd14, 1'b0, 1'b0}; len[2] = 34;
        t[3] = '{8'd34, 8'd14, 1'b0, 1'b0}; len[3] = 34;
        t[4] = '{8'd34, 8'd14, 1'b0, 1'b0}; len[4] = 34;
        t[5] = '{8'd34, 8'd14, 1'b1, 1'b0}; len[5] = 34;
        for (int k = 0; k < 6; k++) begin
            sb.push_back(t[k]);
            drive_rise(1'b0);
            got = obs();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL tol rise%0d: got %h, expected %h", k, got, e);
            end
            rest(len[k], 14);
        end
    endtask

    task automatic test_timeout();
        sb.push_back('{period: 8'd34, high_time: 8'd14, locked: 1'b1, timeout: 1'b0});
        drive_rise(1'b0);
        e = sb.pop_front();
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL to start: got %h, expected %h", obs(), e);
        end
        repeat (254) tick();
        vectors++;
        if (bus.phase_cnt !== 8'd254 || bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
            miscompares++;
            $display("FAIL to pre: got pc=%0d to=%b lk=%b, expected 254 0 1", bus.phase_cnt, bus.timeout, bus.locked);
        end
        tick();
        vectors++;
        if (bus.phase_cnt !== 8'd255 || obs() !== exp_t'{8'd34, 8'd14, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL to sat: got pc=%0d %h, expected 255 %h", bus.phase_cnt, obs(), exp_t'{8'd34, 8'd14, 1'b0, 1'b1});
        end
        repeat (3) tick();
        vectors++;
        if (bus.phase_cnt !== 8'd255 || bus.timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL to hold: got pc=%0d to=%b, expected 255 1", bus.phase_cnt, bus.timeout);
        end
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{period: (k == 0) ? 8'd34 : 8'd28, high_time: 8'd14, locked: k == 4, timeout: 1'b0});
            drive_rise(1'b0);
            got = obs();
            e = sb.pop_front();
            vectors++;
            if (got !== e || bus.phase_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL to rise%0d: got %h pc=%0d, expected %h pc=0", k, got, bus.phase_cnt, e);
            end
            rest(28, 14);
        end
    endtask

    task automatic test_simultaneous();
        sb.push_back('{period: 8'd28, high_time: 8'd14, locked: 1'b1, timeout: 1'b0});
        drive_rise(1'b1);
        got = obs();
        e = sb.pop_front();
        vectors++;
        if (got !== e || bus.phase_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL simul: got %h pc=%0d, expected %h pc=0", got, bus.phase_cnt, e);
        end
        rest(28, 10);
        sb.push_back('{period: 8'd28, high_time: 8'd10, locked: 1'b1, timeout: 1'b0});
        drive_rise(1'b0);
        got = obs();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL simul next: got %h, expected %h", got, e);
        end
        rest(28, 14);
    endtask

    task automatic test_async_reset();
        drive_rise(1'b0);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs() !== exp_t'(0) || bus.phase_cnt !== 8'd0 || bus.sample_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL async rst: got %h pc=%0d stb=%b, expected 0", obs(), bus.phase_cnt, bus.sample_stb);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{period: (k == 1) ? 8'd0 : 8'd28, high_time: (k == 1) ? 8'd0 : 8'd14,
                           locked: k == 5, timeout: 1'b0});
            drive_rise(1'b0);
            got = obs();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL relock rise%0d: got %h, expected %h", k, got, e);
            end
            rest(28, 14);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_sample_stb();
        test_tolerance();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
